// File: rtl/u712_m68k_reg_resp.sv
// 68000-protocol target for the U712 8x16 control/status register file; DTACKn-terminated cycles on CLK80 falling edge.
// Optional AS-without-data-strobe bus error is compiled in with U712_REG_RESP_TIMEOUT_EN.
module u712_m68k_reg_resp #(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] ID_VALUE    = 16'h0712,
  parameter int          TIMEOUT     = 32
) (
  input  logic         CLK80,
  input  logic         RESETn,
  input  logic         SELn,
  input  logic         ASn,
  input  logic         UDSn,
  input  logic         LDSn,
  input  logic         RnW,
  input  logic [2:0]   ADDR,
  input  logic [15:0]  DIN,
  output logic [15:0]  DOUT,
  output logic         DOE,
  output logic         DTACKn,
  output logic         BERRn,
  output logic [127:0] REG_OUT
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic        as_m, as_s, uds_m, uds_s, lds_m, lds_s;
  logic [15:0] regs [0:6];
  logic [15:0] reg_all [0:7];
  logic [15:0] rd_data;
  logic [2:0]  addr_q;
  logic        rnw_q, lane_hi, lane_lo;
  logic [3:0]  wait_cnt;
  logic        start;
  logic        berr_idle;

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      as_m  <= 1'b1;
      as_s  <= 1'b1;
      uds_m <= 1'b1;
      uds_s <= 1'b1;
      lds_m <= 1'b1;
      lds_s <= 1'b1;
    end else begin
      as_m  <= ASn;
      as_s  <= as_m;
      uds_m <= UDSn;
      uds_s <= uds_m;
      lds_m <= LDSn;
      lds_s <= lds_m;
    end
  end

`ifdef U712_REG_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          berr_q;

  // Counts only while the cycle is stuck in IDLE waiting for a data strobe.
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      to_cnt <= '0;
      berr_q <= 1'b1;
    end else if (as_s) begin
      to_cnt <= '0;
      berr_q <= 1'b1;
    end else if (berr_q && state == S_IDLE && !SELn && uds_s && lds_s) begin
      if (to_cnt == TW'(TIMEOUT)) berr_q <= 1'b0;
      else                        to_cnt <= to_cnt + 1'b1;
    end else if (berr_q) begin
      to_cnt <= '0;
    end
  end

  assign BERRn     = berr_q;
  assign berr_idle = berr_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign BERRn          = 1'b1;
  assign berr_idle      = 1'b1;
`endif

  assign start = !as_s && !SELn && (!uds_s || !lds_s) && berr_idle;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT:   if (wait_cnt <= 4'd1) state_nxt = S_ACK;
      S_ACK:    state_nxt = S_HOLD;
      S_HOLD:   if (as_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    for (int i = 0; i < 7; i++) reg_all[i] = regs[i];
    reg_all[7] = ID_VALUE;
  end

  assign rd_data = reg_all[ADDR];

  always_comb begin
    REG_OUT = '0;
    for (int i = 0; i < 8; i++) REG_OUT[16*i +: 16] = reg_all[i];
  end

  // Read data is frozen in DECODE so later register writes cannot disturb a cycle in flight.
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < 7; i++) regs[i] <= 16'h0000;
      DOUT     <= 16'h0000;
      DOE      <= 1'b0;
      DTACKn   <= 1'b1;
      addr_q   <= 3'd0;
      rnw_q    <= 1'b1;
      lane_hi  <= 1'b0;
      lane_lo  <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_DECODE: begin
          addr_q   <= ADDR;
          rnw_q    <= RnW;
          lane_hi  <= !uds_s;
          lane_lo  <= !lds_s;
          wait_cnt <= 4'(WAIT_STATES);
          if (RnW) begin
            DOUT <= rd_data;
            DOE  <= 1'b1;
          end
        end
        S_WAIT: wait_cnt <= wait_cnt - 4'd1;
        S_ACK: begin
          DTACKn <= 1'b0;
          if (!rnw_q) begin
            for (int i = 0; i < 7; i++) begin
              if (addr_q == 3'(i)) begin
                if (lane_hi) regs[i][15:8] <= DIN[15:8];
                if (lane_lo) regs[i][7:0]  <= DIN[7:0];
              end
            end
          end
        end
        S_HOLD: begin
          if (as_s) begin
            DTACKn <= 1'b1;
            DOE    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
